// File: rtl/axi4_pkg.sv
// axi4_pkg: slice mode constants and packed payload widths for the AXI4 channels
package axi4_pkg;
  localparam int SLICE_BYPASS = 0;
  localparam int SLICE_FWD = 1;
  localparam int SLICE_SKID = 2;
  function automatic int aw_w(input int addr_w, input int id_w, input int user_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + user_w;
  endfunction
  function automatic int ar_w(input int addr_w, input int id_w, input int user_w);
    return aw_w(addr_w, id_w, user_w);
  endfunction
  function automatic int w_w(input int data_w, input int id_w, input int user_w);
    return data_w + data_w / 8 + 1 + id_w + user_w;
  endfunction
  function automatic int b_w(input int id_w, input int user_w);
    return id_w + 2 + user_w;
  endfunction
  function automatic int r_w(input int data_w, input int id_w, input int user_w);
    return id_w + data_w + 2 + 1 + user_w;
  endfunction
endpackage

// File: rtl/axi4_if.sv
// axi4_if: AXI4 link bundle with master and slave views
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 8,
  parameter int ARUSER_W = 1,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W = 1,
  parameter int RUSER_W = 1,
  parameter int BUSER_W = 1
) ();
  localparam int STRB_W = DATA_W / 8;
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic [3:0] awregion;
  logic [AWUSER_W-1:0] awuser;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic wlast;
  logic [ID_W-1:0] wid;
  logic [WUSER_W-1:0] wuser;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic [BUSER_W-1:0] buser;
  logic bvalid;
  logic bready;
  logic [ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic [3:0] arregion;
  logic [ARUSER_W-1:0] aruser;
  logic arvalid;
  logic arready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic [RUSER_W-1:0] ruser;
  logic rvalid;
  logic rready;
  modport master_mp (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input awready,
    output wdata, wstrb, wlast, wid, wuser, wvalid,
    input wready,
    input bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );
  modport slave_mp (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input wdata, wstrb, wlast, wid, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input rready
  );
endinterface

// File: rtl/axi4_skid_slice.sv
// axi4_skid_slice: one valid/ready channel stage, bypass, forward register or full skid
module axi4_skid_slice
  import axi4_pkg::*;
#(
  parameter int W = 8,
  parameter int MODE = SLICE_SKID
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  if (MODE == SLICE_BYPASS) begin : g_byp
    assign out_valid = in_valid;
    assign out_data = in_data;
    assign in_ready = out_ready;
  end else if (MODE == SLICE_FWD) begin : g_fwd
    logic out_v_q, out_v_d;
    logic [W-1:0] out_d_q, out_d_d;
    assign in_ready = !out_v_q || out_ready;
    assign out_valid = out_v_q;
    assign out_data = out_d_q;
    always_comb begin
      out_v_d = in_ready ? in_valid : out_v_q;
      out_d_d = (in_ready && in_valid) ? in_data : out_d_q;
    end
    always_ff @(posedge clk) begin
      out_d_q <= out_d_d;
      out_v_q <= rst ? 1'b0 : out_v_d;
    end
  end else begin : g_skid
    logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d, push;
    logic [W-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
    assign in_ready = rdy_q;
    assign out_valid = main_v_q;
    assign out_data = main_d_q;
    assign push = in_valid && rdy_q;
    always_comb begin
      main_v_d = main_v_q;
      main_d_d = main_d_q;
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      if (skid_v_q) begin
        if (out_ready) begin
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end
      end else if (!main_v_q || out_ready) begin
        main_v_d = push;
        main_d_d = push ? in_data : main_d_q;
      end else if (push) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data;
      end
      rdy_d = !skid_v_d;
    end
    always_ff @(posedge clk) begin
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      if (rst) begin
        main_v_q <= 1'b0;
        skid_v_q <= 1'b0;
        rdy_q <= 1'b0;
      end else begin
        main_v_q <= main_v_d;
        skid_v_q <= skid_v_d;
        rdy_q <= rdy_d;
      end
    end
  end
endmodule

// File: rtl/axi4_reg_slice.sv
// axi4_reg_slice: AXI4 register slice with an independent stage on each of the five channels
module axi4_reg_slice
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 8,
  parameter int ARUSER_W = 1,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W = 1,
  parameter int RUSER_W = 1,
  parameter int BUSER_W = 1,
  parameter int AW_MODE = SLICE_SKID,
  parameter int W_MODE = SLICE_SKID,
  parameter int B_MODE = SLICE_SKID,
  parameter int AR_MODE = SLICE_SKID,
  parameter int R_MODE = SLICE_SKID
) (
  input logic clk,
  input logic rst,
  axi4_if.slave_mp s_axi,
  axi4_if.master_mp m_axi
);
  localparam int AW_PW = aw_w(ADDR_W, ID_W, AWUSER_W);
  localparam int W_PW = w_w(DATA_W, ID_W, WUSER_W);
  localparam int B_PW = b_w(ID_W, BUSER_W);
  localparam int AR_PW = ar_w(ADDR_W, ID_W, ARUSER_W);
  localparam int R_PW = r_w(DATA_W, ID_W, RUSER_W);
  logic [AW_PW-1:0] aw_in, aw_out;
  logic [W_PW-1:0] w_in, w_out;
  logic [B_PW-1:0] b_in, b_out;
  logic [AR_PW-1:0] ar_in, ar_out;
  logic [R_PW-1:0] r_in, r_out;
  assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.awlock,
                  s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion, s_axi.awuser};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
          m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion, m_axi.awuser} = aw_out;
  assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wid, s_axi.wuser};
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wid, m_axi.wuser} = w_out;
  assign b_in = {m_axi.bid, m_axi.bresp, m_axi.buser};
  assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;
  assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst, s_axi.arlock,
                  s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion, s_axi.aruser};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
          m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion, m_axi.aruser} = ar_out;
  assign r_in = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
  assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;
  axi4_skid_slice #(.W(AW_PW), .MODE(AW_MODE)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
    .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
  );
  axi4_skid_slice #(.W(W_PW), .MODE(W_MODE)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
    .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
  );
  axi4_skid_slice #(.W(B_PW), .MODE(B_MODE)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
    .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
  );
  axi4_skid_slice #(.W(AR_PW), .MODE(AR_MODE)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
    .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
  );
  axi4_skid_slice #(.W(R_PW), .MODE(R_MODE)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
    .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
  );
endmodule

// File: tb/tb_axi4_reg_slice.sv
// tb_axi4_reg_slice: directed checks of the AXI4 register slice in skid and mixed-mode builds
module tb_axi4_reg_slice;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  axi4_if s_if ();
  axi4_if m_if ();
  axi4_if s2 ();
  axi4_if m2 ();
  axi4_reg_slice dut (.clk(clk), .rst(rst), .s_axi(s_if), .m_axi(m_if));
  axi4_reg_slice #(.B_MODE(0), .AW_MODE(1)) dut2 (.clk(clk), .rst(rst), .s_axi(s2), .m_axi(m2));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock, s_if.awcache,
     s_if.awprot, s_if.awqos, s_if.awregion, s_if.awuser, s_if.awvalid} = '0;
    {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wid, s_if.wuser, s_if.wvalid, s_if.bready} = '0;
    {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock, s_if.arcache,
     s_if.arprot, s_if.arqos, s_if.arregion, s_if.aruser, s_if.arvalid, s_if.rready} = '0;
    {m_if.awready, m_if.wready, m_if.bid, m_if.bresp, m_if.buser, m_if.bvalid, m_if.arready} = '0;
    {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.ruser, m_if.rvalid} = '0;
    {s2.awid, s2.awaddr, s2.awlen, s2.awsize, s2.awburst, s2.awlock, s2.awcache,
     s2.awprot, s2.awqos, s2.awregion, s2.awuser, s2.awvalid} = '0;
    {s2.wdata, s2.wstrb, s2.wlast, s2.wid, s2.wuser, s2.wvalid, s2.bready} = '0;
    {s2.arid, s2.araddr, s2.arlen, s2.arsize, s2.arburst, s2.arlock, s2.arcache,
     s2.arprot, s2.arqos, s2.arregion, s2.aruser, s2.arvalid, s2.rready} = '0;
    {m2.awready, m2.wready, m2.bid, m2.bresp, m2.buser, m2.bvalid, m2.arready} = '0;
    {m2.rid, m2.rdata, m2.rresp, m2.rlast, m2.ruser, m2.rvalid} = '0;
  endtask
  initial begin
    int k, n_out, n_in, last_t, seen;
    idle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 5'b0);
      chk("rst_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, 5'b0);
    end
    rst = 1'b0;
    step();
    chk("post_rst_ready", {s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 5'b11111);
    chk("post_rst_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, 5'b0);
    m2.bvalid = 1'b1;
    m2.bid = 8'h07;
    m2.bresp = 2'b10;
    s2.bready = 1'b1;
    #1;
    chk("byp_b_fwd", {s2.bvalid, s2.bid, s2.bresp}, {1'b1, 8'h07, 2'b10});
    chk("byp_b_rdy1", m2.bready, 1'b1);
    s2.bready = 1'b0;
    #1;
    chk("byp_b_rdy0", m2.bready, 1'b0);
    m2.bvalid = 1'b0;
    #1;
    chk("byp_b_vld0", s2.bvalid, 1'b0);
    s2.awvalid = 1'b1;
    s2.awid = 8'h09;
    s2.awaddr = 32'h0000_2000;
    m2.awready = 1'b0;
    #1;
    chk("fwd_aw_rdy_empty", s2.awready, 1'b1);
    step();
    s2.awvalid = 1'b0;
    #1;
    chk("fwd_aw_out", {m2.awvalid, m2.awid, m2.awaddr}, {1'b1, 8'h09, 32'h0000_2000});
    chk("fwd_aw_rdy_held", s2.awready, 1'b0);
    m2.awready = 1'b1;
    #1;
    chk("fwd_aw_rdy_comb", s2.awready, 1'b1);
    step();
    chk("fwd_aw_drained", m2.awvalid, 1'b0);
    m2.awready = 1'b0;
    s_if.arvalid = 1'b1;
    s_if.arid = 8'd5;
    s_if.araddr = 32'h0000_1000;
    s_if.arlen = 8'd3;
    s_if.arburst = 2'b01;
    m_if.arready = 1'b0;
    #1;
    chk("ar_before", m_if.arvalid, 1'b0);
    step();
    s_if.arvalid = 1'b0;
    s_if.araddr = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ar_held", {m_if.arvalid, m_if.arid, m_if.araddr, m_if.arlen, m_if.arburst},
          {1'b1, 8'd5, 32'h0000_1000, 8'd3, 2'b01});
      step();
    end
    m_if.arready = 1'b1;
    step();
    chk("ar_done", m_if.arvalid, 1'b0);
    m_if.arready = 1'b0;
    k = 1;
    n_out = 0;
    for (int t = 0; t < 20; t++) begin
      m_if.wready = !(t >= 3 && t <= 5);
      s_if.wvalid = (k <= 8);
      s_if.wdata = 32'(k);
      s_if.wlast = (k == 8);
      @(negedge clk);
      if (t == 3) chk("w_rdy_skid_fill", s_if.wready, 1'b1);
      if (t == 4) chk("w_rdy_fall", s_if.wready, 1'b0);
      if (t == 7) chk("w_rdy_rise", s_if.wready, 1'b1);
      if (s_if.wvalid && s_if.wready) k++;
      if (m_if.wvalid && m_if.wready) begin
        n_out++;
        chk("w_beat", {m_if.wdata, m_if.wlast}, {32'(n_out), n_out == 8});
      end
      step();
    end
    chk("w_count", n_out, 8);
    s_if.wvalid = 1'b0;
    m_if.wready = 1'b0;
    s_if.rready = 1'b1;
    n_out = 0;
    n_in = 0;
    last_t = -1;
    for (int t = 0; t < 270; t++) begin
      m_if.rvalid = (t < 256);
      m_if.rdata = 32'(t + 1);
      m_if.rid = 8'h3C;
      m_if.rresp = 2'b01;
      m_if.rlast = (t == 255);
      @(negedge clk);
      if (m_if.rvalid && m_if.rready) n_in++;
      if (s_if.rvalid && s_if.rready) begin
        n_out++;
        last_t = t;
        chk("r_beat", {s_if.rid, s_if.rresp, s_if.rlast, s_if.rdata},
            {8'h3C, 2'b01, n_out == 256, 32'(n_out)});
      end
      step();
    end
    chk("r_in_count", n_in, 256);
    chk("r_out_count", n_out, 256);
    chk("r_cycles", last_t + 1, 257);
    s_if.rready = 1'b0;
    m_if.awready = 1'b0;
    s_if.awvalid = 1'b1;
    s_if.awaddr = 32'hAAAA_0000;
    step();
    s_if.awaddr = 32'hBBBB_0000;
    step();
    s_if.awvalid = 1'b0;
    #1;
    chk("aw_full", {m_if.awvalid, s_if.awready, m_if.awaddr}, {2'b10, 32'hAAAA_0000});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("aw_rst_vld", m_if.awvalid, 1'b0);
    chk("aw_rst_rdy", s_if.awready, 1'b0);
    m_if.awready = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (m_if.awvalid) seen++;
      step();
    end
    chk("aw_dropped", seen, 0);
    chk("aw_rdy_back", s_if.awready, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
